signed_divider: RTL
===================

SIGNED_DIVIDER -- requirements
Module: signed_divider

Interface
REQ-001 The block SHALL expose the following ports, one per line below: name, direction, width, meaning.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low.
REQ-004 load  input  1  single-cycle start pulse, already debounced/edge-detected upstream.
REQ-005 dividend  input  16  signed two's-complement dividend.
REQ-006 divisor  input  8  signed two's-complement divisor.
REQ-007 quotient  output  16  signed two's-complement quotient, truncated toward zero.
REQ-008 remainder  output  8  signed two's-complement remainder; sign follows dividend.
REQ-009 q_abs  output  16  unsigned quotient magnitude, for direct feed to the BCD converter.
REQ-010 q_sign  output  1  1 = quotient negative; drives the display sign digit.
REQ-011 busy  output  1  high while iterating.
REQ-012 done  output  1  high while a valid result is held.
REQ-013 div_zero  output  1  divisor-zero flag (see Configuration).

Function
REQ-014 FSM states: IDLE, RUN, DONE; reset enters IDLE.
REQ-015 IDLE/DONE + load=1 -> RUN; operands and their signs captured that edge; done cleared the next cycle.
REQ-016 load while in RUN is ignored; captured operands are unaffected.
REQ-017 RUN: unsigned restoring division of |dividend| (17-bit safe, 32768 representable) by |divisor|, one quotient bit per cycle, MSB first; 5-bit iteration counter 0..15.
REQ-018 Latency: load accepted at edge N; done=1 and busy=0 from edge N+17; busy=1 for edges N+1..N+16 inclusive.
REQ-019 q_sign = dividend sign XOR divisor sign, forced 0 when quotient magnitude is 0.
REQ-020 remainder sign = dividend sign; a zero remainder is 0.
REQ-021 -32768 / -1: q_abs = 16'h8000, quotient = 16'h8000 (wraps), q_sign = 0; no error flag.
REQ-022 Result outputs update only on entry to DONE; they hold the prior result through RUN.
REQ-023 done holds until the next accepted load or reset; DONE without load stays DONE.

Reset
REQ-024 rst=0 at a clock edge: state IDLE; quotient, remainder, q_abs = 0; q_sign, busy, done, div_zero = 0.
REQ-025 Reset mid-RUN aborts the operation; no partial result is exposed; the next load starts a clean operation.
REQ-026 Reset takes priority over a simultaneous load.

Configuration
REQ-027 Macro DIVIDER_DIV_ZERO_DETECT_EN.
REQ-028 Defined: divisor = 0 at load -> DONE at edge N+1, skipping RUN; quotient = 0, remainder = 0, q_sign = 0, div_zero = 1; div_zero clears on the next accepted load.
REQ-029 Undefined: div_zero tied 0; zero divisor runs the full 17-cycle RUN; q_abs = 16'hFFFF; quotient and remainder are unspecified.

Verification
REQ-030 dividend = 100, divisor = 7, load pulse -> after 17 cycles quotient = 14, remainder = 2, q_sign = 0, done = 1.
REQ-031 dividend = -100 (16'hFF9C), divisor = 7 -> quotient = -14 (16'hFFF2), remainder = -2 (8'hFE), q_abs = 14, q_sign = 1.
REQ-032 dividend = -32768, divisor = -1 -> quotient = 16'h8000, q_abs = 16'h8000, q_sign = 0, remainder = 0.
REQ-033 Second load pulse at cycle 5 of RUN with new operands -> ignored; first result appears at cycle 17 unchanged.
REQ-034 rst=0 at cycle 8 of RUN, then release -> all outputs 0 and state IDLE; a new load of 50/-5 yields quotient = -10, remainder = 0.
REQ-035 divisor = 0 with macro defined -> done = 1 and div_zero = 1 one cycle after load, quotient = 0; with macro undefined -> done after 17 cycles, q_abs = 16'hFFFF, div_zero = 0.

Source files
------------

// File: rtl/signed_divider.sv
// signed_divider
//   Iterative 16-bit / 8-bit signed divider. It runs a restoring division on
//   the operand magnitudes and produces one quotient bit per cycle, MSB first.
//   It then applies the result signs: the quotient truncates toward zero and
//   the remainder takes the sign of the dividend.
//
//   Optional feature macro: DIVIDER_DIV_ZERO_DETECT_EN
//     defined   : a zero divisor finishes one cycle after load, with zero
//                 results and div_zero=1.
//     undefined : div_zero is tied 0 and a zero divisor runs the full
//                 iteration, which gives q_abs=16'hFFFF.
//
// Handshake: load is a single-cycle start pulse. It is accepted only in IDLE
//   or DONE, and the operands are captured on that edge. busy is high while
//   iterating. done is high while a valid result is held, and it holds until
//   the next accepted load or reset. A load seen while busy is dropped.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-low reset
//   load        in   start pulse
//   dividend    in   16-bit signed
//   divisor     in   8-bit signed
//   quotient    out  16-bit signed quotient
//   remainder   out  8-bit signed remainder
//   q_abs       out  16-bit quotient magnitude
//   q_sign      out  1 = quotient negative (0 for a zero magnitude)
//   busy        out  iterating
//   done        out  result valid
//   div_zero    out  divisor-zero flag
//   o_dbg_state out  FSM state (0 IDLE, 1 RUN, 2 DONE)
module signed_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic [15:0] q_abs,
  output logic        q_sign,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      r_state;
  logic [15:0] r_dvd;      // dividend magnitude; quotient bits shift in at LSB
  logic [7:0]  r_dvs;      // divisor magnitude
  logic [8:0]  r_rem;      // partial remainder, one spare bit for the shift
  logic [4:0]  r_cnt;
  logic        r_sd;       // dividend sign
  logic        r_ss;       // divisor sign
  logic [15:0] r_quotient;
  logic [7:0]  r_remainder;
  logic [15:0] r_q_abs;
  logic        r_q_sign;
  logic        r_busy;
  logic        r_done;
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
  logic        r_zero;
  logic        r_div_zero;
`endif

  // The 16-bit unsigned magnitude is exact for -32768 (0x8000). The same holds
  // for -128 (0x80) in the 8-bit divisor.
  logic [15:0] w_dvd_mag;
  logic [7:0]  w_dvs_mag;
  logic [8:0]  w_trial;
  logic        w_ge;
  logic        w_q_neg;
  logic [7:0]  w_rem_mag;

  assign w_dvd_mag = dividend[15] ? (~dividend + 16'd1) : dividend;
  assign w_dvs_mag = divisor[7]   ? (~divisor + 8'd1)   : divisor;
  assign w_trial   = {r_rem[7:0], r_dvd[15]};
  assign w_ge      = (w_trial >= {1'b0, r_dvs});
  assign w_q_neg   = (r_sd ^ r_ss) && (r_dvd != 16'd0);
  assign w_rem_mag = r_rem[7:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_sd        <= 1'b0;
      r_ss        <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_q_abs     <= '0;
      r_q_sign    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
      r_zero      <= 1'b0;
      r_div_zero  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (load) begin
            r_state <= RUN;
            r_dvd   <= w_dvd_mag;
            r_dvs   <= w_dvs_mag;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_sd    <= dividend[15];
            r_ss    <= divisor[7];
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
            r_zero     <= (divisor == 8'd0);
            r_div_zero <= 1'b0;
`endif
          end
        end
        RUN: begin
          r_done <= 1'b0;
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
          if (r_zero) begin
            r_state     <= DONE;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_q_abs     <= '0;
            r_q_sign    <= 1'b0;
            r_div_zero  <= 1'b1;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
          end else
`endif
          if (r_cnt == 5'd16) begin
            // All 16 quotient bits are in r_dvd. Publish the signed results.
            r_state     <= DONE;
            r_q_abs     <= r_dvd;
            r_q_sign    <= w_q_neg;
            r_quotient  <= w_q_neg ? (~r_dvd + 16'd1) : r_dvd;
            r_remainder <= r_sd ? (~w_rem_mag + 8'd1) : w_rem_mag;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_rem  <= w_ge ? (w_trial - {1'b0, r_dvs}) : w_trial;
            r_dvd  <= {r_dvd[14:0], w_ge};
            r_cnt  <= r_cnt + 5'd1;
            r_busy <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign q_abs       = r_q_abs;
  assign q_sign      = r_q_sign;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;
`ifdef DIVIDER_DIV_ZERO_DETECT_EN
  assign div_zero    = r_div_zero;
`else
  assign div_zero    = 1'b0;
`endif

endmodule
